// File: rtl/hififo_pkg.sv
// Shared definitions for the hififo_pcie TLP transmit arbiter: skid depth,
// FSM state encoding and the round-robin search function.
package hififo_pkg;

   localparam int SKID_DEPTH = 2;

   typedef enum logic {
      IDLE = 1'b0,
      PKT  = 1'b1
   } state_t;

   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } rr_t;

   // Winner is the first requester strictly after 'last', wrapping at nch.
   function automatic rr_t next_rr(input logic [15:0] req, input logic [3:0] last,
                                   input int nch);
      rr_t r;
      int  c;
      r = '0;
      for (int k = 1; k <= 16; k++) begin
         c = (int'(last) + k) % nch;
         if (!r.found && (k <= nch) && req[c[3:0]]) begin
            r.found = 1'b1;
            r.idx   = c[3:0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/hififo_tx_arb_if.sv
// Channel-side and core-side AXI-stream TLP signals of the transmit arbiter.
// The arbiter uses the slave view; sources and the core model use master.
interface hififo_tx_arb_if #(
   parameter int NCH = 8,
   parameter int DW  = 64
);
   logic [NCH*DW-1:0] c_tdata;
   logic [NCH-1:0]    c_tlast;
   logic [NCH-1:0]    c_1dw;
   logic [NCH-1:0]    c_tvalid;
   logic [NCH-1:0]    c_tready;
   logic [DW-1:0]     s_axis_tx_tdata;
   logic              s_axis_tx_1dw;
   logic              s_axis_tx_tlast;
   logic              s_axis_tx_tvalid;
   logic              s_axis_tx_tready;

   modport master (
      output c_tdata, c_tlast, c_1dw, c_tvalid, s_axis_tx_tready,
      input  c_tready, s_axis_tx_tdata, s_axis_tx_1dw, s_axis_tx_tlast, s_axis_tx_tvalid
   );

   modport slave (
      input  c_tdata, c_tlast, c_1dw, c_tvalid, s_axis_tx_tready,
      output c_tready, s_axis_tx_tdata, s_axis_tx_1dw, s_axis_tx_tlast, s_axis_tx_tvalid
   );
endinterface

// File: rtl/hififo_skid2.sv
// Two-entry {data, last, 1dw} skid buffer; in_ready comes from the count flop
// only, so the core's tready never reaches the channel ready paths.
module hififo_skid2
   import hififo_pkg::*;
#(
   parameter int DW = 64
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   input  logic          in_1dw,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          out_1dw,
   output logic          out_valid,
   input  logic          out_ready
);
   localparam int W = DW + 2;

   logic [W-1:0] e0, e1, din;
   logic [1:0]   count;
   logic         push, pop;

   assign din       = {in_data, in_last, in_1dw};
   assign in_ready  = (count != 2'(SKID_DEPTH));
   assign out_valid = (count != 2'd0);
   assign {out_data, out_last, out_1dw} = e0;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // e0 is always the head; e1 only holds the second entry when count==2.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         e0    <= '0;
         e1    <= '0;
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) e0 <= din;
               else               e1 <= din;
               count <= count + 2'd1;
            end
            2'b01: begin
               e0    <= e1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  e0 <= din;
               end else begin
                  e0 <= e1;
                  e1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/hififo_tx_arb.sv
// Packet-atomic round-robin TLP transmit arbiter feeding pcie_core_wrap s_axis_tx.
// Define HIFIFO_TX_ARB_STATS_EN to build the per-channel accepted-TLP counters.
module hififo_tx_arb
   import hififo_pkg::*;
#(
   parameter int          NCH    = 8,
   parameter logic [15:0] ENABLE = 16'hFFFF,
   parameter int          DW     = 64
) (
   input  logic              clock,
   input  logic              reset_n,
   hififo_tx_arb_if.slave    bus,
   output logic [3:0]        grant,
   output logic              busy,
   output logic [NCH*16-1:0] tlp_count
);
   state_t        state, state_nxt;
   logic [3:0]    last_grant, grant_nxt;
   logic [15:0]   req;
   rr_t           rr;
   logic [DW-1:0] sel_data;
   logic          sel_last, sel_1dw, sel_valid;
   logic          skid_ready, push;

   always_comb begin
      req          = '0;
      req[NCH-1:0] = bus.c_tvalid & ENABLE[NCH-1:0];
   end

   assign rr = next_rr(req, last_grant, NCH);

   always_comb begin
      sel_data  = '0;
      sel_last  = 1'b0;
      sel_1dw   = 1'b0;
      sel_valid = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (grant == 4'(i)) begin
            sel_data  = bus.c_tdata[i*DW +: DW];
            sel_last  = bus.c_tlast[i];
            sel_1dw   = bus.c_1dw[i];
            sel_valid = bus.c_tvalid[i];
         end
      end
   end

   assign push = (state == PKT) & sel_valid & skid_ready;
   assign busy = (state == PKT);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         grant      <= 4'd0;
         last_grant <= 4'(NCH - 1);
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         if (state == IDLE && rr.found) last_grant <= rr.idx;
      end
   end

   // Leaving PKT on the tlast beat costs one IDLE cycle before the next grant.
   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant;
      bus.c_tready = '0;
      case (state)
         IDLE: begin
            if (rr.found) begin
               state_nxt = PKT;
               grant_nxt = rr.idx;
            end
         end
         PKT: begin
            for (int i = 0; i < NCH; i++) begin
               if (grant == 4'(i)) bus.c_tready[i] = skid_ready;
            end
            if (push && sel_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   hififo_skid2 #(.DW(DW)) u_skid (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_data   (sel_data),
      .in_last   (sel_last),
      .in_1dw    (sel_1dw),
      .in_valid  ((state == PKT) & sel_valid),
      .in_ready  (skid_ready),
      .out_data  (bus.s_axis_tx_tdata),
      .out_last  (bus.s_axis_tx_tlast),
      .out_1dw   (bus.s_axis_tx_1dw),
      .out_valid (bus.s_axis_tx_tvalid),
      .out_ready (bus.s_axis_tx_tready)
   );

`ifdef HIFIFO_TX_ARB_STATS_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tlp_count <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (push && sel_last && grant == 4'(i))
               tlp_count[i*16 +: 16] <= tlp_count[i*16 +: 16] + 16'd1;
         end
      end
   end
`else
   assign tlp_count = '0;
`endif

endmodule

// File: tb/tb_hififo_tx_arb.sv
// Directed bench for hififo_tx_arb: dut_a has all channels enabled,
// dut_b uses ENABLE=16'h00FE for the masking/wrap scenario.
module tb_hififo_tx_arb;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   hififo_tx_arb_if #(.NCH(8), .DW(64)) ia ();
   hififo_tx_arb_if #(.NCH(8), .DW(64)) ib ();

   logic [3:0]   grant_a, grant_b;
   logic         busy_a, busy_b;
   logic [127:0] cnt_a, cnt_b;

   hififo_tx_arb #(.NCH(8), .ENABLE(16'hFFFF), .DW(64)) dut_a (
      .clock(clock), .reset_n(reset_n), .bus(ia),
      .grant(grant_a), .busy(busy_a), .tlp_count(cnt_a)
   );

   hififo_tx_arb #(.NCH(8), .ENABLE(16'h00FE), .DW(64)) dut_b (
      .clock(clock), .reset_n(reset_n), .bus(ib),
      .grant(grant_b), .busy(busy_b), .tlp_count(cnt_b)
   );

   int tests = 0;
   int fails = 0;

   logic [63:0] src_data [8][8];
   int          src_len [8];
   int          src_ptr [8];

   int          out_n[$];
   logic [63:0] out_d[$];
   logic        out_l[$];
   logic        out_w[$];
   int          acc_ch[$];
   int          acc_n[$];
   logic        busy_log [64];
   logic [3:0]  grant_log [64];
   logic [7:0]  rdy_log [64];

   task automatic clear_src();
      for (int c = 0; c < 8; c++) begin
         src_len[c] = 0;
         src_ptr[c] = 0;
      end
   endtask

   // Drives dut_a channel sources from src_* for ncyc cycles and logs what happens.
   task automatic run_sources(input int ncyc, input int rdy_after);
      logic [7:0] acc;
      out_n.delete(); out_d.delete(); out_l.delete(); out_w.delete();
      acc_ch.delete(); acc_n.delete();
      for (int n = 0; n < ncyc; n++) begin
         ia.s_axis_tx_tready = (n >= rdy_after);
         for (int c = 0; c < 8; c++) begin
            if (src_ptr[c] < src_len[c]) begin
               ia.c_tvalid[c]          = 1'b1;
               ia.c_tdata[c*64 +: 64]  = src_data[c][src_ptr[c]];
               ia.c_tlast[c]           = (src_ptr[c] == src_len[c] - 1);
               ia.c_1dw[c]             = src_data[c][src_ptr[c]][0];
            end else begin
               ia.c_tvalid[c] = 1'b0;
               ia.c_tlast[c]  = 1'b0;
               ia.c_1dw[c]    = 1'b0;
            end
         end
         #1;
         busy_log[n]  = busy_a;
         grant_log[n] = grant_a;
         rdy_log[n]   = ia.c_tready;
         if (ia.s_axis_tx_tvalid && ia.s_axis_tx_tready) begin
            out_n.push_back(n);
            out_d.push_back(ia.s_axis_tx_tdata);
            out_l.push_back(ia.s_axis_tx_tlast);
            out_w.push_back(ia.s_axis_tx_1dw);
         end
         acc = ia.c_tvalid & ia.c_tready;
         for (int c = 0; c < 8; c++) begin
            if (acc[c]) begin
               acc_ch.push_back(c);
               acc_n.push_back(n);
            end
         end
         @(posedge clock); #1;
         for (int c = 0; c < 8; c++) if (acc[c]) src_ptr[c]++;
      end
      ia.c_tvalid = '0;
      ia.c_tlast  = '0;
      ia.c_1dw    = '0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      tests++; if (ia.s_axis_tx_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid got %b want 0", ia.s_axis_tx_tvalid); end
      tests++; if (ia.s_axis_tx_tdata !== 64'h0) begin fails++; $display("FAIL reset_tdata got %h want 0", ia.s_axis_tx_tdata); end
      tests++; if ({ia.s_axis_tx_tlast, ia.s_axis_tx_1dw} !== 2'b00) begin fails++; $display("FAIL reset_last_1dw got %b want 00", {ia.s_axis_tx_tlast, ia.s_axis_tx_1dw}); end
      tests++; if ({ia.c_tready, ib.c_tready} !== 16'h0) begin fails++; $display("FAIL reset_c_tready got %h want 0", {ia.c_tready, ib.c_tready}); end
      tests++; if ({grant_a, busy_a, busy_b} !== 6'h0) begin fails++; $display("FAIL reset_grant_busy got %h want 0", {grant_a, busy_a, busy_b}); end
      tests++; if (cnt_a !== 128'h0) begin fails++; $display("FAIL reset_tlp_count got %h want 0", cnt_a); end
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      ia.s_axis_tx_tready = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(posedge clock); #1;
         tests++; if ({busy_a, ia.s_axis_tx_tvalid, ia.c_tready} !== 10'h0) begin fails++; $display("FAIL idle_quiet cyc %0d got %h want 0", n, {busy_a, ia.s_axis_tx_tvalid, ia.c_tready}); end
      end
   endtask

   task automatic test_single();
      logic [63:0] e [3];
      e[0] = 64'h11; e[1] = 64'h22; e[2] = 64'h33;
      clear_src();
      src_len[0] = 3;
      for (int k = 0; k < 3; k++) src_data[0][k] = e[k];
      run_sources(7, 0);
      tests++; if (busy_log[0] !== 1'b0) begin fails++; $display("FAIL single_busy0 got %b want 0", busy_log[0]); end
      tests++; if ({busy_log[1], grant_log[1]} !== 5'b1_0000) begin fails++; $display("FAIL single_grant got busy %b grant %0d want busy 1 grant 0", busy_log[1], grant_log[1]); end
      tests++; if (busy_log[4] !== 1'b0) begin fails++; $display("FAIL single_release got %b want 0", busy_log[4]); end
      tests++; if (out_d.size() !== 3) begin fails++; $display("FAIL single_out_count got %0d want 3", out_d.size()); end
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (k >= out_d.size() || out_d[k] !== e[k] || out_n[k] !== k + 2 ||
             out_l[k] !== (k == 2) || out_w[k] !== e[k][0] || acc_n[k] !== k + 1) begin
            fails++;
            $display("FAIL single_beat%0d got data %h cyc %0d last %b want data %h cyc %0d last %b",
                     k, (k < out_d.size()) ? out_d[k] : 64'hx, (k < out_n.size()) ? out_n[k] : -1,
                     (k < out_l.size()) ? out_l[k] : 1'bx, e[k], k + 2, (k == 2));
         end
      end
   endtask

   task automatic test_contention();
      logic [63:0] e [4];
      int          ec [4];
      int          en [4];
      e[0] = 64'hB1; e[1] = 64'hB2; e[2] = 64'hA1; e[3] = 64'hA2;
      ec[0] = 5; ec[1] = 5; ec[2] = 2; ec[3] = 2;
      en[0] = 1; en[1] = 2; en[2] = 4; en[3] = 5;
      clear_src();
      src_len[2] = 1; src_data[2][0] = 64'hA0;
      run_sources(4, 0);
      tests++; if (acc_ch.size() !== 1 || acc_ch[0] !== 2) begin fails++; $display("FAIL contention_prime got %0d accepts want 1 on ch2", acc_ch.size()); end
      clear_src();
      src_len[2] = 2; src_data[2][0] = 64'hA1; src_data[2][1] = 64'hA2;
      src_len[5] = 2; src_data[5][0] = 64'hB1; src_data[5][1] = 64'hB2;
      run_sources(9, 0);
      tests++; if (acc_ch.size() !== 4 || out_d.size() !== 4) begin fails++; $display("FAIL contention_count got %0d/%0d want 4/4", acc_ch.size(), out_d.size()); end
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (k >= acc_ch.size() || k >= out_d.size() || acc_ch[k] !== ec[k] ||
             acc_n[k] !== en[k] || out_d[k] !== e[k]) begin
            fails++;
            $display("FAIL contention_beat%0d got ch %0d cyc %0d data %h want ch %0d cyc %0d data %h", k,
                     (k < acc_ch.size()) ? acc_ch[k] : -1, (k < acc_n.size()) ? acc_n[k] : -1,
                     (k < out_d.size()) ? out_d[k] : 64'hx, ec[k], en[k], e[k]);
         end
      end
      tests++; if ({busy_log[3], rdy_log[3]} !== 9'h0) begin fails++; $display("FAIL contention_bubble got busy %b ready %h want 0 0", busy_log[3], rdy_log[3]); end
   endtask

   task automatic test_backpressure();
      logic [63:0]  e [4];
      int           en [4];
      logic [127:0] ecnt;
      e[0] = 64'hC1; e[1] = 64'hC2; e[2] = 64'hC3; e[3] = 64'hC4;
      en[0] = 1; en[1] = 2; en[2] = 9; en[3] = 10;
      clear_src();
      src_len[1] = 4;
      for (int k = 0; k < 4; k++) src_data[1][k] = e[k];
      run_sources(14, 8);
      tests++; if (acc_n.size() !== 4) begin fails++; $display("FAIL bp_accept_count got %0d want 4", acc_n.size()); end
      for (int k = 3; k <= 8; k++) begin
         tests++; if (rdy_log[k][1] !== 1'b0) begin fails++; $display("FAIL bp_stall cyc %0d got %b want 0", k, rdy_log[k][1]); end
      end
      tests++; if (out_d.size() !== 4) begin fails++; $display("FAIL bp_out_count got %0d want 4", out_d.size()); end
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (k >= out_d.size() || k >= acc_n.size() || out_d[k] !== e[k] ||
             out_n[k] !== k + 8 || acc_n[k] !== en[k]) begin
            fails++;
            $display("FAIL bp_beat%0d got data %h cyc %0d want data %h cyc %0d", k,
                     (k < out_d.size()) ? out_d[k] : 64'hx, (k < out_n.size()) ? out_n[k] : -1, e[k], k + 8);
         end
      end
      ecnt = '0;
`ifdef HIFIFO_TX_ARB_STATS_EN
      ecnt[15:0] = 16'd1; ecnt[31:16] = 16'd1; ecnt[47:32] = 16'd2; ecnt[95:80] = 16'd1;
`endif
      tests++; if (cnt_a !== ecnt) begin fails++; $display("FAIL stats_counts got %h want %h", cnt_a, ecnt); end
   endtask

   task automatic test_mask_wrap();
      int n7;
      n7 = 0;
      ib.s_axis_tx_tready = 1'b1;
      ib.c_tdata = '0;
      ib.c_tdata[0 +: 64]  = 64'h55;
      ib.c_tdata[448 +: 64] = 64'h77;
      ib.c_tlast = 8'h81;
      ib.c_1dw   = 8'h00;
      ib.c_tvalid = 8'h81;
      for (int n = 0; n < 8; n++) begin
         #1;
         tests++; if (ib.c_tready[0] !== 1'b0) begin fails++; $display("FAIL mask_ready0 cyc %0d got %b want 0", n, ib.c_tready[0]); end
         if (n >= 1) begin
            tests++; if (grant_b !== 4'd7) begin fails++; $display("FAIL mask_grant cyc %0d got %0d want 7", n, grant_b); end
         end
         if (ib.s_axis_tx_tvalid) begin
            tests++; if (ib.s_axis_tx_tdata !== 64'h77) begin fails++; $display("FAIL mask_data cyc %0d got %h want 77", n, ib.s_axis_tx_tdata); end
         end
         if (ib.c_tready[7] && ib.c_tvalid[7]) n7++;
         @(posedge clock); #1;
      end
      ib.c_tvalid = '0;
      tests++; if (n7 !== 4) begin fails++; $display("FAIL mask_ch7_accepts got %0d want 4", n7); end
   endtask

   task automatic test_reset_mid();
      logic [127:0] ecnt;
      clear_src();
      src_len[3] = 4;
      for (int k = 0; k < 4; k++) src_data[3][k] = 64'hD1 + 64'(k);
      run_sources(3, 99);
      tests++; if (acc_n.size() !== 2) begin fails++; $display("FAIL rst_mid_pre got %0d accepts want 2", acc_n.size()); end
      reset_n = 1'b0;
      #1;
      tests++; if ({ia.s_axis_tx_tvalid, ia.s_axis_tx_tlast, ia.s_axis_tx_1dw, ia.c_tready, busy_a, grant_a} !== 16'h0) begin fails++; $display("FAIL rst_mid_ctrl got %h want 0", {ia.s_axis_tx_tvalid, ia.s_axis_tx_tlast, ia.s_axis_tx_1dw, ia.c_tready, busy_a, grant_a}); end
      tests++; if (ia.s_axis_tx_tdata !== 64'h0) begin fails++; $display("FAIL rst_mid_tdata got %h want 0", ia.s_axis_tx_tdata); end
      tests++; if (cnt_a !== 128'h0) begin fails++; $display("FAIL rst_mid_count got %h want 0", cnt_a); end
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      @(posedge clock); #1;
      clear_src();
      src_len[3] = 2; src_data[3][0] = 64'hE1; src_data[3][1] = 64'hE2;
      run_sources(6, 0);
      tests++;
      if (out_d.size() !== 2 || out_d[0] !== 64'hE1 || out_d[1] !== 64'hE2 ||
          out_n[0] !== 2 || out_n[1] !== 3 || out_l[1] !== 1'b1) begin
         fails++;
         $display("FAIL rst_mid_next got %0d beats first %h want 2 beats E1,E2 at cyc 2,3",
                  out_d.size(), (out_d.size() > 0) ? out_d[0] : 64'hx);
      end
      ecnt = '0;
`ifdef HIFIFO_TX_ARB_STATS_EN
      ecnt[63:48] = 16'd1;
`endif
      tests++; if (cnt_a !== ecnt) begin fails++; $display("FAIL rst_mid_stats got %h want %h", cnt_a, ecnt); end
   endtask

   initial begin
      ia.c_tdata = '0; ia.c_tlast = '0; ia.c_1dw = '0; ia.c_tvalid = '0; ia.s_axis_tx_tready = 1'b0;
      ib.c_tdata = '0; ib.c_tlast = '0; ib.c_1dw = '0; ib.c_tvalid = '0; ib.s_axis_tx_tready = 1'b0;
      clear_src();
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_mask_wrap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
